// File: rtl/rv32i_bus_pkg.sv
// Shared types and constants for the RV32I data-bus fabric: FSM encoding, error data, default map.
// Combinational only; no timing or flow-control behaviour lives here.
package rv32i_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_W = 16;

  localparam logic [31:0] RAM_BASE   = 32'h1000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_C000;
  localparam logic [31:0] TIMER_BASE = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_BASE  = 32'hFFFF_1000;
  localparam logic [31:0] UART_BASE  = 32'hFFFF_2000;
  localparam logic [31:0] PERIPH_MASK = 32'hFFFF_F000;

  // Slave 0 sits in the least significant word.
  localparam logic [127:0] DEF_BASE_ADDRS = {UART_BASE, GPIO_BASE, TIMER_BASE, RAM_BASE};
  localparam logic [127:0] DEF_ADDR_MASKS = {PERIPH_MASK, PERIPH_MASK, PERIPH_MASK, RAM_MASK};

endpackage

// File: rtl/rv32i_data_bus_fabric_if.sv
// CPU load/store port plus slave-side bus of the data fabric.
// slave modport is the fabric's view; master is the CPU core together with the slave devices.
interface rv32i_data_bus_fabric_if #(
  parameter int NSLV = 4
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [3:0]           cpu_be;
  logic                 cpu_gnt;
  logic                 cpu_rvalid;
  logic [31:0]          cpu_rdata;
  logic                 cpu_err;
  logic [NSLV-1:0]      s_cs;
  logic                 s_we;
  logic [3:0]           s_be;
  logic [31:0]          s_addr;
  logic [31:0]          s_wdata;
  logic [NSLV-1:0]      s_rdy;
  logic [NSLV*32-1:0]   s_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, s_rdy, s_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, s_cs, s_we, s_be, s_addr, s_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, s_rdy, s_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, s_cs, s_we, s_be, s_addr, s_wdata
  );

endinterface

// File: rtl/rv32i_data_bus_fabric_addr_decoder.sv
// Combinational address decoder: one-hot select of the lowest-index matching slave, plus hit flag.
// Zero latency; no flow control.
module rv32i_addr_decoder #(
  parameter int                NSLV       = 4,
  parameter logic [NSLV*32-1:0] BASE_ADDRS = '0,
  parameter logic [NSLV*32-1:0] ADDR_MASKS = '0
) (
  input  logic [31:0]     addr,
  output logic [NSLV-1:0] sel,
  output logic            hit
);

  // Walk high to low so the lowest matching index is the last one written.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if ((addr & ADDR_MASKS[k*32 +: 32]) == BASE_ADDRS[k*32 +: 32]) begin
        sel    = '0;
        sel[k] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32i_data_bus_fabric.sv
// CPU data-port fabric: req@T0 grant, s_cs@T1, rvalid one cycle after s_rdy; unmapped -> rvalid@T1 with error.
// Slaves stall via s_rdy; no new grant until the response has issued. BUS_TIMEOUT_EN bounds the stall.
module rv32i_data_bus_fabric
  import rv32i_bus_pkg::*;
#(
  parameter int                 NSLV        = 4,
  parameter logic [NSLV*32-1:0] BASE_ADDRS  = DEF_BASE_ADDRS,
  parameter logic [NSLV*32-1:0] ADDR_MASKS  = DEF_ADDR_MASKS,
  parameter int                 TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  rv32i_data_bus_fabric_if.slave bus
);

  if (NSLV < 1 || NSLV > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC >= 2**TIMEOUT_W) begin : g_bad_cfg
    $error("rv32i_data_bus_fabric: unsupported NSLV or TIMEOUT_CYC");
  end

  bus_state_t      state_q, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
`ifdef BUS_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`endif

  logic [NSLV-1:0] dec_sel;
  logic            dec_hit;
  logic            gnt;
  logic            slv_rdy;
  logic [31:0]     slv_rdata;

  rv32i_addr_decoder #(
    .NSLV       (NSLV),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_dec (
    .addr (bus.cpu_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Select is one-hot, so an OR-reduction is the response mux.
  always_comb begin
    slv_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q[k]) slv_rdata = slv_rdata | bus.s_rdata[k*32 +: 32];
    end
  end

  assign slv_rdy = |(bus.s_rdy & sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          gnt     = 1'b1;
          we_d    = bus.cpu_we;
          be_d    = bus.cpu_be;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          if (dec_hit) begin
            sel_d   = dec_sel;
            state_d = ACCESS;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            sel_d   = '0;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (slv_rdy) begin
          rdata_d = we_q ? 32'h0 : slv_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef BUS_TIMEOUT_EN
        // s_rdy takes precedence over a timeout landing in the same cycle.
        else if (cnt_q == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Select and response are decoded from state so reset clears them without waiting for a clock.
  assign bus.cpu_gnt    = gnt & ~reset;
  assign bus.cpu_rvalid = (state_q == RESP);
  assign bus.cpu_rdata  = (state_q == RESP) ? rdata_q : 32'h0;
  assign bus.cpu_err    = (state_q == RESP) & err_q;
  assign bus.s_cs       = (state_q == ACCESS) ? sel_q : '0;
  assign bus.s_we       = we_q;
  assign bus.s_be       = be_q;
  assign bus.s_addr     = addr_q;
  assign bus.s_wdata    = wdata_q;

endmodule

// File: tb/tb_rv32i_data_bus_fabric.sv
// Scoreboard bench for rv32i_data_bus_fabric: expected responses queued at grant, checked at rvalid.
// Map used: RAM, wide TIMER window overlapping GPIO, UART; timeout limit 8 when BUS_TIMEOUT_EN is set.
module tb_rv32i_data_bus_fabric;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  rv32i_data_bus_fabric_if #(.NSLV(4)) bus ();

  rv32i_data_bus_fabric #(
    .NSLV        (4),
    .BASE_ADDRS  ({32'hFFFF_2000, 32'hFFFF_1000, 32'hFFFF_0000, 32'h1000_0000}),
    .ADDR_MASKS  ({32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_C000}),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.cpu_rvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rdata", bus.cpu_rdata, e.rdata);
        check("err", {31'd0, bus.cpu_err}, {31'd0, e.err});
      end
    end
  end

  task automatic run_acc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [3:0] exp_cs, input int waits,
                         input logic [31:0] rd, input logic [3:0] stray);
    int   slv;
    exp_t e;
    slv = 0;
    for (int k = 0; k < 4; k++) if (exp_cs[k]) slv = k;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_be = be;
    @(negedge clk);
    check("gnt", {31'd0, bus.cpu_gnt}, 32'd1);
    check("cs_at_gnt", {28'd0, bus.s_cs}, 32'd0);
    e.err   = (exp_cs == 4'b0000);
    e.rdata = e.err ? 32'hDEAD_BEEF : (we ? 32'h0 : rd);
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom; bus.cpu_be = 4'hF;
    bus.cpu_we = ~we;
    if (exp_cs != 4'b0000) begin
      for (int i = 0; i < waits; i++) begin
        bus.s_rdy   = stray;
        bus.s_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check("cs_wait", {28'd0, bus.s_cs}, {28'd0, exp_cs});
        check("s_addr", bus.s_addr, addr);
        check("s_wdata", bus.s_wdata, wd);
        check("s_be_we", {27'd0, bus.s_be, bus.s_we}, {27'd0, be, we});
        check("rvalid_wait", {31'd0, bus.cpu_rvalid}, 32'd0);
        @(posedge clk); #1;
      end
      bus.s_rdy = exp_cs;
      bus.s_rdata[slv*32 +: 32] = rd;
      @(negedge clk);
      check("cs_rdy", {28'd0, bus.s_cs}, {28'd0, exp_cs});
      @(posedge clk); #1;
      bus.s_rdy = 4'b0000;
    end
    @(negedge clk);
    check("rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    check("cs_resp", {28'd0, bus.s_cs}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
    bus.s_rdy = '0; bus.s_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_err, bus.s_we, bus.s_cs, bus.s_be},
          32'd0);
    check("rst_addr", bus.s_addr, 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Zero-wait RAM load, wait-state UART store, unmapped load.
    run_acc(1'b0, 32'h1000_0010, 32'h0, 4'hF, 4'b0001, 0, 32'h1234_5678, 4'b0000);
    run_acc(1'b1, 32'hFFFF_2000, 32'hA5A5_A5A5, 4'b0001, 4'b1000, 5, 32'h5555_5555, 4'b0000);
    run_acc(1'b0, 32'h0000_0000, 32'h0, 4'hF, 4'b0000, 0, 32'h0, 4'b0000);
    // Overlap between slaves 1 and 2 with stray ready on slave 2 and on the idle RAM channel.
    run_acc(1'b0, 32'hFFFF_1004, 32'h0, 4'hF, 4'b0010, 3, 32'hCAFE_F00D, 4'b0101);
    run_acc(1'b1, 32'h1000_0040, 32'h0102_0304, 4'b0000, 4'b0001, 1, 32'h7777_0000, 4'b0000);
    run_acc(1'b0, 32'hFFFF_2FFC, 32'h0, 4'b1100, 4'b1000, 2, 32'h0BAD_F00D, 4'b0010);

    // Slave that never answers.
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hFFFF_0008; bus.cpu_be = 4'hF;
    @(negedge clk);
    check("to_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
`ifdef BUS_TIMEOUT_EN
    e.rdata = 32'hDEAD_BEEF; e.err = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_cs", {28'd0, bus.s_cs}, 32'd2);
    end
    @(negedge clk);
    check("to_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    check("to_cs_drop", {28'd0, bus.s_cs}, 32'd0);
`else
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("pend_cs", {28'd0, bus.s_cs}, 32'd2);
    check("pend_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    e.rdata = 32'h600D_0001; e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.s_rdy = 4'b0010; bus.s_rdata[63:32] = 32'h600D_0001;
    @(posedge clk); #1 bus.s_rdy = 4'b0000;
    @(negedge clk);
    check("pend_rvalid_end", {31'd0, bus.cpu_rvalid}, 32'd1);
`endif

    // Reset in the second ACCESS cycle discards the access.
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1000_0100; bus.cpu_be = 4'hF;
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rs_cs1", {28'd0, bus.s_cs}, 32'd1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("rs_cs_async", {28'd0, bus.s_cs}, 32'd0);
    check("rs_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rs_idle_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);

    run_acc(1'b0, 32'h1000_0020, 32'h0, 4'hF, 4'b0001, 1, 32'h8765_4321, 4'b0000);
    repeat (3) @(posedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
